bus_arbiter_rr: RTL and testbench

- Parametrised successor to the current bus arbiter. Takes NREQ bus requesters (icache, dcache, future DMA and peripherals) and grants the shared bus to at most one of them.
- Grant is registered and held for a whole transaction, not recomputed every cycle.
- Arbitration mode is selectable: fixed priority or round-robin.
- A beat-count limit can force the current owner off the bus so others are not starved; a per-requester lock suppresses this.
- Sits between requesters' bus_req/bus_ack and the OR-combined shared bus; bus_ready comes from the slave.

---
 rtl/bus_pkg.sv | 18 +
 rtl/rr_pick.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 99 +++++++++
 tb/tb_bus_arbiter_rr.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter family: requester indices, the arbiter
// state type and the grant-index width rule.
package bus_pkg;

  localparam int unsigned BUS_ICACHE = 0;
  localparam int unsigned BUS_DCACHE = 1;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_e;

  // Width of an index into n requesters, never less than one bit.
  function automatic int unsigned bus_idxw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: lowest set index, or first set index after a
// start pointer with wrap-around.
module rr_pick
  import bus_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = bus_idxw(N)
) (
  input  logic [N-1:0]    elig,
  input  logic [IDXW-1:0] ptr,
  input  logic            rr_mode,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  always_comb begin
    int unsigned j;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = rr_mode ? (32'(ptr) + 1 + k) % N : k;
      if (!valid && elig[j]) begin
        valid = 1'b1;
        idx   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Registered bus arbiter: holds a grant for a whole transaction, with fixed or
// round-robin selection and optional beat-count preemption.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int unsigned  NREQ      = 8,
  parameter int unsigned  RR_MODE   = 1,
  parameter int unsigned  MAX_BEATS = 16,
  localparam int unsigned IDXW      = bus_idxw(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] bus_req,
  input  logic [NREQ-1:0] bus_lock,
  input  logic            bus_ready,
  output logic [NREQ-1:0] bus_ack,
  output logic [IDXW-1:0] bus_gnt_idx,
  output logic            bus_busy,
  output logic            bus_preempt
);

  localparam int unsigned BW = bus_idxw(MAX_BEATS + 1);

  arb_state_e      state_q;
  logic [NREQ-1:0] ack_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] ptr_q;
  logic [BW-1:0]   beats_q;
  logic            preempt_q;

  logic            owner_req;
  logic            others_req;
  logic            owner_lock;
  logic            at_cap;
  logic            preempt;
  logic            take_grant;
  logic [NREQ-1:0] elig;
  logic [IDXW-1:0] win_idx;
  logic            win_valid;

  // ack_q is one-hot (or zero), so masking with it isolates the owner's bits.
  always_comb begin
    owner_req  = |(bus_req & ack_q);
    others_req = |(bus_req & ~ack_q);
    owner_lock = |(bus_lock & ack_q);
    at_cap     = (beats_q == BW'(MAX_BEATS));
    preempt    = (state_q == ARB_OWN) && owner_req && (MAX_BEATS != 0) && at_cap &&
                 bus_ready && !owner_lock && others_req;
    take_grant = (state_q == ARB_IDLE) || !owner_req || preempt;
    elig       = preempt ? (bus_req & ~ack_q) : bus_req;
  end

  rr_pick #(
    .N    (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .elig    (elig),
    .ptr     (ptr_q),
    .rr_mode (RR_MODE != 0),
    .idx     (win_idx),
    .valid   (win_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      ack_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= IDXW'(NREQ - 1);
      beats_q   <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= preempt;
      if (take_grant) begin
        // Handoff goes straight to the next winner, no idle cycle in between.
        if (win_valid) begin
          state_q <= ARB_OWN;
          ack_q   <= NREQ'(1) << win_idx;
          idx_q   <= win_idx;
          ptr_q   <= win_idx;
          beats_q <= '0;
        end else begin
          state_q <= ARB_IDLE;
          ack_q   <= '0;
          idx_q   <= '0;
          beats_q <= '0;
        end
      end else if (bus_ready && !at_cap) begin
        beats_q <= beats_q + 1'b1;
      end
    end
  end

  assign bus_ack     = ack_q;
  assign bus_gnt_idx = idx_q;
  assign bus_busy    = (state_q == ARB_OWN);
  assign bus_preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: two configurations driven from shared stimulus and
// checked against a grant-level reference model, plus directed corner cases.
module tb_bus_arbiter_rr;
  import bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lock;
  logic       rdy;

  logic [2:0] ack_a;
  logic [1:0] idx_a;
  logic       busy_a;
  logic       pre_a;
  logic [3:0] ack_b;
  logic [1:0] idx_b;
  logic       busy_b;
  logic       pre_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: 3 requesters, round-robin, preempt after 4 beats.
  bus_arbiter_rr #(
    .NREQ      (3),
    .RR_MODE   (1),
    .MAX_BEATS (4)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .bus_req     (req[2:0]),
    .bus_lock    (lock[2:0]),
    .bus_ready   (rdy),
    .bus_ack     (ack_a),
    .bus_gnt_idx (idx_a),
    .bus_busy    (busy_a),
    .bus_preempt (pre_a)
  );

  // B: 4 requesters, fixed priority, never preempts.
  bus_arbiter_rr #(
    .NREQ      (4),
    .RR_MODE   (0),
    .MAX_BEATS (0)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .bus_req     (req),
    .bus_lock    (lock),
    .bus_ready   (rdy),
    .bus_ack     (ack_b),
    .bus_gnt_idx (idx_b),
    .bus_busy    (busy_b),
    .bus_preempt (pre_b)
  );

  // Reference model: who owns the bus, the last winner, beats taken.
  int m_owner[2];
  int m_ptr[2];
  int m_beats[2];
  bit m_pre[2];

  function automatic int n_of(input int d);
    return (d == 0) ? 3 : 4;
  endfunction

  function automatic bit rr_of(input int d);
    return d == 0;
  endfunction

  function automatic int maxb_of(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_ptr[d]   = n_of(d) - 1;
      m_beats[d] = 0;
      m_pre[d]   = 1'b0;
    end
  endfunction

  // Winner = requesting index with the smallest rank; round-robin rank is the
  // distance travelled upward from the slot after the last winner.
  function automatic int pick(input int d, input logic [3:0] r);
    int best = -1;
    int best_rank = 1000;
    int rank;
    int n = n_of(d);
    for (int j = 0; j < n; j++) begin
      if (r[j]) begin
        rank = rr_of(d) ? (j - m_ptr[d] - 1 + 2 * n) % n : j;
        if (rank < best_rank) begin
          best_rank = rank;
          best = j;
        end
      end
    end
    return best;
  endfunction

  function automatic void model_step(input int d, input logic [3:0] req_v,
                                     input logic [3:0] lock_v, input logic rdy_v);
    logic [3:0] r;
    logic [3:0] omask;
    int  o;
    int  w;
    bit  rel;
    bit  pre;
    int  mask = (1 << n_of(d)) - 1;
    r = req_v & 4'(mask);
    m_pre[d] = 1'b0;
    if (m_owner[d] < 0) begin
      w = pick(d, r);
      if (w >= 0) begin
        m_owner[d] = w; m_ptr[d] = w; m_beats[d] = 0;
      end
    end else begin
      o = m_owner[d];
      omask = 4'(1 << o);
      rel = !r[o];
      pre = !rel && (maxb_of(d) > 0) && (m_beats[d] == maxb_of(d)) && rdy_v &&
            !lock_v[o] && ((r & ~omask) != 4'b0);
      if (rel) begin
        w = pick(d, r);
        if (w >= 0) begin
          m_owner[d] = w; m_ptr[d] = w; m_beats[d] = 0;
        end else begin
          m_owner[d] = -1;
        end
      end else if (pre) begin
        w = pick(d, r & ~omask);
        m_owner[d] = w; m_ptr[d] = w; m_beats[d] = 0;
        m_pre[d] = 1'b1;
      end else if (rdy_v && m_beats[d] < maxb_of(d)) begin
        m_beats[d] = m_beats[d] + 1;
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int oa = m_owner[0];
    int ob = m_owner[1];
    check("ack_a", int'(ack_a), (oa < 0) ? 0 : (1 << oa));
    check("busy_a", int'(busy_a), int'(oa >= 0));
    check("pre_a", int'(pre_a), int'(m_pre[0]));
    if (oa >= 0) check("idx_a", int'(idx_a), oa);
    check("ack_b", int'(ack_b), (ob < 0) ? 0 : (1 << ob));
    check("busy_b", int'(busy_b), int'(ob >= 0));
    check("pre_b", int'(pre_b), int'(m_pre[1]));
    if (ob >= 0) check("idx_b", int'(idx_b), ob);
  endtask

  // Called at a negedge: drive, let one active edge pass, then compare.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rd);
    req  = r;
    lock = l;
    rdy  = rd;
    @(posedge clk);
    model_step(0, r, l, rd);
    model_step(1, r, l, rd);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [2:0] ack_a;
    logic [3:0] ack_b;
  } vec_t;

  vec_t tbl[24];

  initial begin
    // All requesting, one beat each: A grants 0,1,2,0 (pointer wraps).
    tbl[0]  = '{4'b0111, 1'b0, 3'b001, 4'b0001};
    tbl[1]  = '{4'b0111, 1'b1, 3'b001, 4'b0001};
    tbl[2]  = '{4'b0110, 1'b0, 3'b010, 4'b0010};
    tbl[3]  = '{4'b0111, 1'b1, 3'b010, 4'b0010};
    tbl[4]  = '{4'b0101, 1'b0, 3'b100, 4'b0001};
    tbl[5]  = '{4'b0111, 1'b1, 3'b100, 4'b0001};
    tbl[6]  = '{4'b0011, 1'b0, 3'b001, 4'b0001};
    tbl[7]  = '{4'b0111, 1'b1, 3'b001, 4'b0001};
    // Two masters alternating with back-to-back handoffs.
    tbl[8]  = '{4'b0011, 1'b0, 3'b001, 4'b0001};
    tbl[9]  = '{4'b0011, 1'b1, 3'b001, 4'b0001};
    tbl[10] = '{4'b0011, 1'b1, 3'b001, 4'b0001};
    tbl[11] = '{4'b0010, 1'b0, 3'b010, 4'b0010};
    tbl[12] = '{4'b0011, 1'b1, 3'b010, 4'b0010};
    tbl[13] = '{4'b0011, 1'b1, 3'b010, 4'b0010};
    tbl[14] = '{4'b0001, 1'b0, 3'b001, 4'b0001};
    tbl[15] = '{4'b0011, 1'b1, 3'b001, 4'b0001};
    tbl[16] = '{4'b0011, 1'b1, 3'b001, 4'b0001};
    tbl[17] = '{4'b0010, 1'b0, 3'b010, 4'b0010};
    tbl[18] = '{4'b0000, 1'b0, 3'b000, 4'b0000};
    // Owner 1 keeps the bus while 0 waits, then 0 follows.
    tbl[19] = '{4'b0010, 1'b0, 3'b010, 4'b0010};
    tbl[20] = '{4'b0011, 1'b0, 3'b010, 4'b0010};
    tbl[21] = '{4'b0011, 1'b0, 3'b010, 4'b0010};
    tbl[22] = '{4'b0001, 1'b0, 3'b001, 4'b0001};
    tbl[23] = '{4'b0000, 1'b0, 3'b000, 4'b0000};
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  found;

    rst  = 1'b1;
    req  = 4'b0;
    lock = 4'b0;
    rdy  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ack_a", int'(ack_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_idx_a", int'(idx_a), 0);
    check("rst_pre_a", int'(pre_a), 0);
    check("rst_ack_b", int'(ack_b), 0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].req, 4'b0, tbl[i].rdy);
      check($sformatf("tbl%0d_ack_a", i), int'(ack_a), int'(tbl[i].ack_a));
      check($sformatf("tbl%0d_ack_b", i), int'(ack_b), int'(tbl[i].ack_b));
    end

    // Preemption of unlocked owner 1 while 0 waits, ready every cycle.
    step(4'b0010, 4'b0, 1'b0);
    check("pre_grant1", int'(ack_a), 3'b010);
    found = 1'b0;
    k = 0;
    while (!found && k < 8) begin
      k++;
      step(4'b0011, 4'b0, 1'b1);
      if (pre_a) found = 1'b1;
    end
    check("pre_seen", int'(found), 1);
    check("pre_ready_cycles", k, 5);
    check("pre_ack", int'(ack_a), 3'b001);
    check("pre_to_icache", int'(idx_a), int'(BUS_ICACHE));
    step(4'b0011, 4'b0, 1'b0);
    check("pre_single_pulse", int'(pre_a), 0);
    step(4'b0010, 4'b0, 1'b0);
    check("pre_regrant", int'(idx_a), int'(BUS_DCACHE));

    // Locked owner is never preempted, however many beats.
    for (int i = 0; i < 10; i++) begin
      step(4'b0011, 4'b0010, 1'b1);
      check("lock_no_pre", int'(pre_a), 0);
      check("lock_hold", int'(ack_a), 3'b010);
    end
    // Drop req while unlocked and at the limit: plain release.
    step(4'b0001, 4'b0, 1'b1);
    check("drop_at_limit_ack", int'(ack_a), 3'b001);
    check("drop_at_limit_pre", int'(pre_a), 0);

    // Asynchronous reset in the middle of owner 2's transfer.
    step(4'b0100, 4'b0, 1'b0);
    check("mid_grant2", int'(ack_a), 3'b100);
    step(4'b0100, 4'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("async_ack_a", int'(ack_a), 0);
    check("async_busy_a", int'(busy_a), 0);
    check("async_ack_b", int'(ack_b), 0);
    #1;
    rst = 1'b0;
    model_reset();
    step(4'b0100, 4'b0, 1'b0);
    check("post_rst_ack", int'(ack_a), 3'b100);

    // Random traffic: requests stay up for a while, locks and ready vary.
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] r;
      r = req;
      for (int b = 0; b < 4; b++) begin
        if (r[b]) begin
          if ($urandom_range(0, 5) == 0) r[b] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          r[b] = 1'b1;
        end
      end
      step(r, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
